// File: rtl/nandy_pkg.sv
// Shared constants for the Nandy NAND-family datapath blocks.
// Holds the function-select encodings and the legal pipeline-depth range.
package nandy_pkg;

  localparam logic [1:0] MODE_NAND  = 2'b00;
  localparam logic [1:0] MODE_AND   = 2'b01;
  localparam logic [1:0] MODE_NOTA  = 2'b10;
  localparam logic [1:0] MODE_PASSA = 2'b11;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  // Operand B only matters to the two-input functions.
  function automatic logic mode_uses_b(input logic [1:0] mode);
    return (mode == MODE_NAND) || (mode == MODE_AND);
  endfunction

endpackage

// File: rtl/nand_pipe_stage.sv
// One elastic register slice (valid, data, xerr); 1 cycle latency.
// Loads whenever load is high, so the slice holds its contents while downstream stalls.
module nand_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int XERR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic [XERR_W-1:0] src_xerr,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [XERR_W-1:0] xerr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      xerr  <= '0;
    end else if (load) begin
      valid <= src_valid;
      // Bubbles leave the old payload in place so the output never glitches.
      if (src_valid) begin
        data <= src_data;
        xerr <= src_xerr;
      end
    end
  end

endmodule

// File: rtl/nand_pipe_bank.sv
// Multi-channel NAND-family function feeding a STAGES-deep elastic pipeline; latency STAGES.
// in_ready is combinational from out_ready: a full pipe accepts on the same edge it delivers.
module nand_pipe_bank
  import nandy_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int X_CHECK  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_q,
  output logic [CHANNELS-1:0]       out_xerr,
  output logic [15:0]               out_count
);

  localparam int DW = CHANNELS * WIDTH;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("nand_pipe_bank: STAGES out of range");
  end

  logic [DW-1:0]       fn_q;
  logic [CHANNELS-1:0] fn_xerr;

  always_comb begin
    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic [WIDTH-1:0] r_k;
    logic             x_k;
    fn_q    = '0;
    fn_xerr = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      a_k = in_a[k*WIDTH +: WIDTH];
      b_k = in_b[k*WIDTH +: WIDTH];
      x_k = 1'b0;
      case (in_mode)
        MODE_NAND: r_k = ~(a_k & b_k);
        MODE_AND:  r_k = a_k & b_k;
        MODE_NOTA: r_k = ~a_k;
        default:   r_k = a_k;
      endcase
`ifndef SYNTHESIS
      // Poisoned channels are forced to all-X so nothing downstream trusts them.
      if (X_CHECK != 0) begin
        x_k = $isunknown(a_k) || (mode_uses_b(in_mode) && $isunknown(b_k));
        if (x_k) r_k = 'x;
      end
`endif
      fn_q[k*WIDTH +: WIDTH] = r_k;
      fn_xerr[k]             = x_k;
    end
  end

  logic [STAGES-1:0]   stg_valid;
  logic [DW-1:0]       stg_data [STAGES];
  logic [CHANNELS-1:0] stg_xerr [STAGES];
  logic [STAGES:0]     stg_ready;

  // Ready ripples back from the output: a slice can load if empty or if it is moving on.
  always_comb begin
    stg_ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stg_ready[i] = !stg_valid[i] || stg_ready[i+1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic                src_valid;
    logic [DW-1:0]       src_data;
    logic [CHANNELS-1:0] src_xerr;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = fn_q;
      assign src_xerr  = fn_xerr;
    end else begin : g_body
      assign src_valid = stg_valid[i-1];
      assign src_data  = stg_data[i-1];
      assign src_xerr  = stg_xerr[i-1];
    end

    nand_pipe_stage #(
      .DATA_W (DW),
      .XERR_W (CHANNELS)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (stg_ready[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_xerr  (src_xerr),
      .valid     (stg_valid[i]),
      .data      (stg_data[i]),
      .xerr      (stg_xerr[i])
    );
  end

  assign in_ready  = stg_ready[0];
  assign out_valid = stg_valid[STAGES-1];
  assign out_q     = stg_data[STAGES-1];
  assign out_xerr  = (X_CHECK != 0) ? stg_xerr[STAGES-1] : '0;

  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign out_count = count_q;

endmodule

// File: tb/tb_nand_pipe_bank.sv
// Scoreboard bench for nand_pipe_bank: expectations are queued on accept and checked on delivery.
// Inputs change 1ns after posedge; everything is sampled on negedge.
module tb_nand_pipe_bank;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int DW = W * C;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_q;
  logic [C-1:0]  out_xerr;
  logic [15:0]   out_count;

  always #5 clk = ~clk;

  nand_pipe_bank #(
    .WIDTH    (W),
    .CHANNELS (C),
    .STAGES   (ST),
    .X_CHECK  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_xerr  (out_xerr),
    .out_count (out_count)
  );

  typedef struct {
    logic [DW-1:0] q;
    logic [C-1:0]  xe;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [15:0]   exp_cnt = '0;
  logic [DW-1:0] last_q = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [1:0] m);
    exp_t       e;
    logic [W-1:0] ak, bk, r;
    logic       xf;
    e.q  = '0;
    e.xe = '0;
    for (int k = 0; k < C; k++) begin
      ak = a[k*W +: W];
      bk = b[k*W +: W];
      case (m)
        2'b00:   r = ~(ak & bk);
        2'b01:   r = ak & bk;
        2'b10:   r = ~ak;
        default: r = ak;
      endcase
      xf = $isunknown(ak) || ((m == 2'b00 || m == 2'b01) && $isunknown(bk));
      if (xf) r = 'x;
      e.q[k*W +: W] = r;
      e.xe[k]       = xf;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_q", {32'd0, out_q}, {32'd0, e.q});
          chk("sb_xerr", {60'd0, out_xerr}, {60'd0, e.xe});
          chk("sb_cnt", {48'd0, out_count}, {48'd0, exp_cnt});
        end
        exp_cnt = exp_cnt + 16'd1;
        last_q  = out_q;
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_mode));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = '0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Offers one set and returns 1ns after the edge that accepted it.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] m, output int stalls);
    bit acc;
    acc      = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int            st;
    int            tot;
    int            idx;
    bit            acc;
    bit            held;
    logic [DW-1:0] hold_q;
    logic [C-1:0]  hold_x;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] bp_a [4];

    in_a      = '0;
    in_b      = '0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    do_reset();

    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_q", {32'd0, out_q}, 64'd0);
    chk("rst_xerr", {60'd0, out_xerr}, 64'd0);
    chk("rst_cnt", {48'd0, out_count}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Single NAND set with a latency probe.
    send(32'hFF00_F0AA, 32'hFFFF_0F55, 2'b00, st);
    idle();
    @(negedge clk);
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_ontime", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    drain();
    chk("nand_q", {32'd0, last_q}, {32'd0, 32'h00FF_FFFF});
    chk("nand_cnt", {48'd0, out_count}, 64'd1);

    send(32'h1234_5678, 32'h0F0F_0F0F, 2'b01, st);
    idle();
    drain();
    chk("and_q", {32'd0, last_q}, {32'd0, 32'h0204_0608});
    send(32'h1234_5678, 32'h0F0F_0F0F, 2'b10, st);
    idle();
    drain();
    chk("nota_q", {32'd0, last_q}, {32'd0, 32'hEDCB_A987});
    send(32'h1234_5678, 32'h0F0F_0F0F, 2'b11, st);
    idle();
    drain();
    chk("passa_q", {32'd0, last_q}, {32'd0, 32'h1234_5678});

    // Back-to-back stream.
    do_reset();
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom, 2'($urandom_range(0, 3)), st);
      tot += st;
    end
    idle();
    drain();
    chk("stream_stalls", 64'(tot), 64'd0);
    chk("stream_cnt", {48'd0, out_count}, 64'd10);

    // Backpressure: out_ready low for 5 cycles while 4 sets are offered.
    for (int i = 0; i < 4; i++) bp_a[i] = $urandom;
    out_ready = 1'b0;
    idx  = 0;
    held = 1'b0;
    hold_q = '0;
    hold_x = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      in_a     = bp_a[idx];
      in_b     = 32'h5A5A_A5A5;
      in_mode  = 2'b00;
      @(negedge clk);
      acc = in_ready;
      if (out_valid) begin
        if (held) begin
          chk("bp_hold_q", {32'd0, out_q}, {32'd0, hold_q});
          chk("bp_hold_x", {60'd0, out_xerr}, {60'd0, hold_x});
        end else begin
          held   = 1'b1;
          hold_q = out_q;
          hold_x = out_xerr;
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'(ST));
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    while (idx < 4) begin
      send(bp_a[idx], 32'h5A5A_A5A5, 2'b00, st);
      idx++;
    end
    idle();
    drain();
    chk("bp_cnt", {48'd0, out_count}, 64'd14);

    // Unknown operands.
    a = 32'h1122_3344;
    a[23:16] = 'x;
    send(a, 32'hF0F0_F0F0, 2'b00, st);
    b = 32'h0F0F_0F0F;
    b[15:8] = 'x;
    send(32'hA5A5_5A5A, b, 2'b10, st);
    idle();
    drain();

    // Reset with two sets in flight, then counter wrap.
    out_ready = 1'b0;
    send($urandom, $urandom, 2'b00, st);
    send($urandom, $urandom, 2'b01, st);
    idle();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_flush_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("rst_flush_cnt", {48'd0, out_count}, 64'd0);
    @(posedge clk);
    #1;
    force dut.count_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    #1;
    release dut.count_q;
    send(32'hDEAD_BEEF, 32'h0000_FFFF, 2'b00, st);
    idle();
    drain();
    chk("cnt_wrap", {48'd0, out_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
